// File: rtl/dpram_param.sv
// dpram_param: simple dual-port RAM with one write port, one read port and one clock.
// A small two-state controller sweeps CLEAR_VAL into every word after reset or
// on a clear request. User traffic is accepted only once the sweep has finished.
// The read path has a valid strobe, an optional output register and a selectable
// same-address read-during-write policy.
module dpram_param #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                OUT_REG   = 1,
  parameter int                RDW_MODE  = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic              wren,
  input  logic [ADDR_W-1:0] rdaddress,
  input  logic              rden,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_accept;
  logic              rd_accept;
  logic              rdw_hit;
  logic [DATA_W-1:0] rd_word;

  // User traffic is only honoured once the sweep has finished.
  assign busy      = (state_q == ST_CLEAR);
  assign wr_accept = (state_q == ST_READY) && wren;
  assign rd_accept = (state_q == ST_READY) && rden;

  // A same-address collision forwards the incoming write data only in new-data
  // mode. In old-data mode the array read already sees the pre-write contents.
  assign rdw_hit = (RDW_MODE != 0) && wr_accept && (wraddress == rdaddress);
  assign rd_word = rdw_hit ? data : mem[rdaddress];

  // The state register and the sweep pointer. Reset, including a reset during a
  // sweep, restarts the sweep at word 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state_q  <= state_d;
      clr_addr <= (state_q == ST_CLEAR) ? clr_addr + 1'b1 : '0;
    end
  end

  // Next-state logic. The sweep leaves after the last word. A clear request is
  // only seen while ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (&clr_addr) state_d = ST_READY;
      ST_READY: if (clear)     state_d = ST_CLEAR;
    endcase
  end

  // Single write port, shared between the sweep and user writes. The sweep
  // owns the port while it runs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_addr] <= CLEAR_VAL;
      end else if (wr_accept) begin
        mem[wraddress] <= data;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_outreg
      logic [DATA_W-1:0] stage_data;
      logic              stage_valid;

      // First read stage: capture the addressed word for an accepted read.
      always_ff @(posedge clock) begin
        if (reset) begin
          stage_valid <= 1'b0;
          stage_data  <= '0;
        end else begin
          stage_valid <= rd_accept;
          if (rd_accept) stage_data <= rd_word;
        end
      end

      // Output register: q changes only when a valid word arrives, so it holds between reads.
      always_ff @(posedge clock) begin
        if (reset) begin
          q_valid <= 1'b0;
          q       <= '0;
        end else begin
          q_valid <= stage_valid;
          if (stage_valid) q <= stage_data;
        end
      end
    end else begin : g_direct
      // Single-stage read: q changes only for an accepted read, so it holds between reads.
      always_ff @(posedge clock) begin
        if (reset) begin
          q_valid <= 1'b0;
          q       <= '0;
        end else begin
          q_valid <= rd_accept;
          if (rd_accept) q <= rd_word;
        end
      end
    end
  endgenerate

endmodule
